// File: rtl/freq_meter_pkg.sv
// ============================================================================
// freq_meter_pkg : FSM state encoding and default parameters for freq_meter
// Rev 1.0
// ============================================================================
`default_nettype none

package freq_meter_pkg;

    localparam int unsigned DEF_GATE_CYCLES = 32'd50_000_000;
    localparam int unsigned DEF_CNT_W       = 32'd32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GATE  = 2'd1,
        LATCH = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/freq_meter_sync_edge.sv
// ============================================================================
// sync_edge : 2-flop synchronizer plus registered rising-edge detector
// Rev 1.0
// ============================================================================
`default_nettype none

module sync_edge (
    input  logic clkin,
    input  logic rst,
    input  logic sigin,
    output logic edge_pulse
);

    logic r_sync1;
    logic r_sync2;
    logic r_sync2_d;

    // Pulse appears three clkin edges after sigin rises.
    always_ff @(posedge clkin or negedge rst) begin
        if (!rst) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_sync2_d  <= 1'b0;
            edge_pulse <= 1'b0;
        end else begin
            r_sync1    <= sigin;
            r_sync2    <= r_sync1;
            r_sync2_d  <= r_sync2;
            edge_pulse <= r_sync2 & ~r_sync2_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/freq_meter.sv
// ============================================================================
// freq_meter : counts sigin rising edges over back-to-back GATE_CYCLES windows
// Rev 1.0
// ============================================================================
`default_nettype none

module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int unsigned GATE_CYCLES = DEF_GATE_CYCLES,
    parameter int unsigned CNT_W       = DEF_CNT_W
) (
    input  logic             clkin,
    input  logic             rst,
    input  logic             en,
    input  logic             sigin,
    output logic [CNT_W-1:0] count_out,
    output logic             done,
    output logic             busy,
    output logic             ovf
);

    localparam logic [31:0]      C_GATE_LAST = 32'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] C_CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_armed;
    logic [31:0]      r_gate_cnt;
    logic [CNT_W-1:0] r_edge_cnt;
    logic             r_sat;
    logic             w_edge_pulse;
    logic             w_gate_last;
    logic [CNT_W-1:0] w_edge_cnt_nxt;
    logic             w_sat_nxt;

    sync_edge u_sync_edge (
        .clkin      (clkin),
        .rst        (rst),
        .sigin      (sigin),
        .edge_pulse (w_edge_pulse)
    );

    assign w_gate_last = (r_gate_cnt == C_GATE_LAST);

    always_comb begin
        w_state_nxt    = r_state;
        w_edge_cnt_nxt = r_edge_cnt;
        w_sat_nxt      = r_sat;

        case (r_state)
            IDLE: begin
                if (en && r_armed) begin
                    w_state_nxt = GATE;
                end
            end
            GATE: begin
                if (!en) begin
                    w_state_nxt = IDLE;
                end else if (w_gate_last) begin
                    w_state_nxt = LATCH;
                end
            end
            LATCH: begin
                w_state_nxt = en ? GATE : IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // Saturating count: hold at max and remember that it happened.
        if (w_edge_pulse) begin
            if (r_edge_cnt == C_CNT_MAX) begin
                w_sat_nxt = 1'b1;
            end else begin
                w_edge_cnt_nxt = r_edge_cnt + C_CNT_ONE;
            end
        end
    end

    // r_armed holds off GATE entry until the second edge after reset release.
    always_ff @(posedge clkin or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_armed <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_armed <= 1'b1;
            busy    <= (w_state_nxt != IDLE);
            done    <= (w_state_nxt == LATCH);
        end
    end

    // Counters only run while staying in GATE; any other path clears them.
    always_ff @(posedge clkin or negedge rst) begin
        if (!rst) begin
            r_gate_cnt <= 32'd0;
            r_edge_cnt <= '0;
            r_sat      <= 1'b0;
        end else if ((r_state == GATE) && (w_state_nxt == GATE)) begin
            r_gate_cnt <= r_gate_cnt + 32'd1;
            r_edge_cnt <= w_edge_cnt_nxt;
            r_sat      <= w_sat_nxt;
        end else begin
            r_gate_cnt <= 32'd0;
            r_edge_cnt <= '0;
            r_sat      <= 1'b0;
        end
    end

    // Results include an edge landing in the final GATE cycle.
    always_ff @(posedge clkin or negedge rst) begin
        if (!rst) begin
            count_out <= '0;
            ovf       <= 1'b0;
        end else if ((r_state == GATE) && (w_state_nxt == LATCH)) begin
            count_out <= w_edge_cnt_nxt;
            ovf       <= w_sat_nxt;
        end
    end

endmodule

`default_nettype wire
